// File: rtl/alu_issue_stage_if.sv
// Instruction handshake, ALU operand/result bus and retire report for alu_issue_stage.
// The slave side is the issue stage; the master side is the instruction source plus the ALU.
interface alu_issue_stage_if;
    logic        ins_valid;
    logic        ins_ready;
    logic [15:0] ins;
    logic [4:0]  alu_op;
    logic [15:0] alu_in1;
    logic [15:0] alu_in2;
    logic [15:0] alu_result;
    logic        retire;
    logic [5:0]  retire_dest;
    logic [15:0] retire_data;

    modport slave (
        input  ins_valid, ins, alu_result,
        output ins_ready, alu_op, alu_in1, alu_in2, retire, retire_dest, retire_data
    );

    modport master (
        output ins_valid, ins, alu_result,
        input  ins_ready, alu_op, alu_in1, alu_in2, retire, retire_dest, retire_data
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Register-read / execute / writeback stage around an external combinational 16-bit ALU.
// Opcodes: 0 add, 1 invf, 2 addf, 3 mulf, 4 xor, 5 and, 6 or, 7 any, 8 dup, 9 shr, 10 f2i, 11 i2f.
module alu_issue_stage #(
    parameter int FP_LAT = 2,
    parameter int NREGS  = 64
) (
    input  logic               clk,
    input  logic               reset,
    alu_issue_stage_if.slave   bus,
    output logic               illegal,
    input  logic               dbg_we,
    input  logic [5:0]         dbg_addr,
    input  logic [15:0]        dbg_wdata,
    output logic [15:0]        dbg_rdata
);
    localparam logic [3:0] LAST_COUNT = 4'(FP_LAT - 1);

    logic [15:0] rf [NREGS];

    logic        exValid;
    logic [3:0]  counter;
    logic [5:0]  exDest;
    logic [4:0]  aluOp;
    logic [15:0] aluIn1;
    logic [15:0] aluIn2;
    logic        retireQ;
    logic [5:0]  retireDest;
    logic [15:0] retireData;
    logic        illegalQ;

    logic [3:0]  exOpcode;
    logic        exIsFloat;
    logic        exIllegal;
    logic        exLast;
    logic        wbFire;
    logic        insReady;
    logic        accept;
    logic [3:0]  insOpcode;
    logic [5:0]  insDest;
    logic [5:0]  insSrc;
    logic        insUnary;
    logic [15:0] srcVal;
    logic [15:0] destVal;
    logic [15:0] operand1;
    logic [15:0] operand2;

    // Execute-stage status: when the current op completes and whether a new one can enter
    always_comb begin
        exOpcode  = aluOp[3:0];
        exIsFloat = (exOpcode == 4'd1) || (exOpcode == 4'd2) || (exOpcode == 4'd3);
        exIllegal = (exOpcode >= 4'd12);
        exLast    = exValid && (!exIsFloat || (counter == LAST_COUNT));
        wbFire    = exLast && !exIllegal;
        insReady  = !reset && !(exValid && exIsFloat && (counter != LAST_COUNT));
        accept    = bus.ins_valid && insReady;
    end

    // Decode and operand fetch; a writeback on this edge forwards its result to the reader
    always_comb begin
        insOpcode = bus.ins[15:12];
        insDest   = bus.ins[11:6];
        insSrc    = bus.ins[5:0];
        insUnary  = (insOpcode == 4'd1) || ((insOpcode >= 4'd7) && (insOpcode <= 4'd11));
        srcVal    = (wbFire && (exDest == insSrc))  ? bus.alu_result : rf[insSrc];
        destVal   = (wbFire && (exDest == insDest)) ? bus.alu_result : rf[insDest];
        operand1  = insUnary ? srcVal : destVal;
        operand2  = srcVal;
    end

    // Execute registers, latency counter, retire report and sticky illegal flag
    always_ff @(posedge clk) begin
        if (reset) begin
            exValid    <= 1'b0;
            counter    <= 4'd0;
            exDest     <= 6'd0;
            aluOp      <= 5'd0;
            aluIn1     <= 16'd0;
            aluIn2     <= 16'd0;
            retireQ    <= 1'b0;
            retireDest <= 6'd0;
            retireData <= 16'd0;
            illegalQ   <= 1'b0;
        end else begin
            if (accept) begin
                aluOp   <= {1'b0, insOpcode};
                exDest  <= insDest;
                aluIn1  <= operand1;
                aluIn2  <= operand2;
                exValid <= 1'b1;
                counter <= 4'd0;
            end else if (exLast) begin
                exValid <= 1'b0;
            end else if (exValid) begin
                counter <= counter + 4'd1;
            end
            retireQ <= wbFire;
            if (wbFire) begin
                retireDest <= exDest;
                retireData <= bus.alu_result;
            end
            if (accept && (insOpcode >= 4'd12)) begin
                illegalQ <= 1'b1;
            end
        end
    end

    // Register file; the writeback assignment comes last so it beats a same-address debug write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= 16'd0;
            end
        end else begin
            if (dbg_we) begin
                rf[dbg_addr] <= dbg_wdata;
            end
            if (wbFire) begin
                rf[exDest] <= bus.alu_result;
            end
        end
    end

    assign bus.ins_ready   = insReady;
    assign bus.alu_op      = aluOp;
    assign bus.alu_in1     = aluIn1;
    assign bus.alu_in2     = aluIn2;
    assign bus.retire      = retireQ;
    assign bus.retire_dest = retireDest;
    assign bus.retire_data = retireData;
    assign illegal         = illegalQ;
    assign dbg_rdata       = rf[dbg_addr];
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a stub ALU and hand-computed expectations.
module tb_alu_issue_stage;
    logic        clk;
    logic        reset;
    logic        illegal;
    logic        dbgWe;
    logic [5:0]  dbgAddr;
    logic [15:0] dbgWdata;
    logic [15:0] dbgRdata;
    int          checks;
    int          errors;

    alu_issue_stage_if bus ();

    alu_issue_stage #(.FP_LAT(2), .NREGS(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .illegal   (illegal),
        .dbg_we    (dbgWe),
        .dbg_addr  (dbgAddr),
        .dbg_wdata (dbgWdata),
        .dbg_rdata (dbgRdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stub ALU: float ops use simple stand-in functions so results are easy to predict
    always_comb begin
        case (bus.alu_op[3:0])
            4'd0:    bus.alu_result = bus.alu_in1 + bus.alu_in2;
            4'd1:    bus.alu_result = ~bus.alu_in2;
            4'd2:    bus.alu_result = bus.alu_in1 - bus.alu_in2;
            4'd3:    bus.alu_result = {bus.alu_in1[7:0], bus.alu_in2[7:0]};
            4'd4:    bus.alu_result = bus.alu_in1 ^ bus.alu_in2;
            4'd5:    bus.alu_result = bus.alu_in1 & bus.alu_in2;
            4'd6:    bus.alu_result = bus.alu_in1 | bus.alu_in2;
            4'd7:    bus.alu_result = {15'd0, |bus.alu_in2};
            4'd8:    bus.alu_result = bus.alu_in2;
            4'd9:    bus.alu_result = bus.alu_in2 >> 1;
            default: bus.alu_result = bus.alu_in2;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [15:0] word);
        bus.ins_valid = valid;
        bus.ins       = word;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic dbgWrite(input logic [5:0] addr, input logic [15:0] data);
        dbgWe    = 1'b1;
        dbgAddr  = addr;
        dbgWdata = data;
        tick();
        dbgWe    = 1'b0;
    endtask

    task automatic checkReg(input string tag, input logic [5:0] addr, input logic [15:0] expected);
        dbgAddr = addr;
        #1;
        checkOutput(tag, dbgRdata, expected);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        dbgWe    = 1'b0;
        dbgAddr  = 6'd0;
        dbgWdata = 16'd0;
        applyStimulus(1'b0, 16'd0);
        tick();
        tick();
        checkOutput("resetReady", {15'd0, bus.ins_ready}, 16'd0);
        checkOutput("resetRetire", {15'd0, bus.retire}, 16'd0);
        checkOutput("resetRetireData", bus.retire_data, 16'd0);
        checkOutput("resetAluOp", {11'd0, bus.alu_op}, 16'd0);
        checkOutput("resetIllegal", {15'd0, illegal}, 16'd0);
        reset = 1'b0;
        #1;
        checkOutput("readyAfterReset", {15'd0, bus.ins_ready}, 16'd1);

        // Simple add R1 = 3 + 5
        dbgWrite(6'd1, 16'h0003);
        dbgWrite(6'd2, 16'h0005);
        applyStimulus(1'b1, 16'h0042);
        tick();
        applyStimulus(1'b0, 16'd0);
        checkOutput("addIn1", bus.alu_in1, 16'h0003);
        checkOutput("addIn2", bus.alu_in2, 16'h0005);
        checkOutput("addNoEarlyRetire", {15'd0, bus.retire}, 16'd0);
        tick();
        checkOutput("addRetire", {15'd0, bus.retire}, 16'd1);
        checkOutput("addDest", {10'd0, bus.retire_dest}, 16'd1);
        checkOutput("addData", bus.retire_data, 16'h0008);
        checkReg("addR1", 6'd1, 16'h0008);

        // Back-to-back dependent add then xor through the bypass
        dbgWrite(6'd1, 16'h0003);
        dbgWrite(6'd3, 16'h00FF);
        applyStimulus(1'b1, 16'h0042);
        tick();
        applyStimulus(1'b1, 16'h40C1);
        checkOutput("b2bReady", {15'd0, bus.ins_ready}, 16'd1);
        tick();
        applyStimulus(1'b0, 16'd0);
        checkOutput("b2bAddData", bus.retire_data, 16'h0008);
        checkOutput("xorIn1", bus.alu_in1, 16'h00FF);
        checkOutput("xorBypassIn2", bus.alu_in2, 16'h0008);
        tick();
        checkOutput("xorDest", {10'd0, bus.retire_dest}, 16'd3);
        checkOutput("xorData", bus.retire_data, 16'h00F7);
        checkReg("xorR3", 6'd3, 16'h00F7);

        // mulf holds the stage for two cycles while the next instruction waits
        dbgWrite(6'd4, 16'h3F80);
        dbgWrite(6'd5, 16'h4000);
        applyStimulus(1'b1, 16'h3105);
        tick();
        applyStimulus(1'b1, 16'h0042);
        checkOutput("mulfStall", {15'd0, bus.ins_ready}, 16'd0);
        checkOutput("mulfOp", {11'd0, bus.alu_op}, 16'd3);
        checkOutput("mulfIn1", bus.alu_in1, 16'h3F80);
        checkOutput("mulfIn2", bus.alu_in2, 16'h4000);
        tick();
        checkOutput("mulfNoRetireYet", {15'd0, bus.retire}, 16'd0);
        checkOutput("mulfReadyAgain", {15'd0, bus.ins_ready}, 16'd1);
        tick();
        applyStimulus(1'b0, 16'd0);
        checkOutput("mulfRetire", {15'd0, bus.retire}, 16'd1);
        checkOutput("mulfDest", {10'd0, bus.retire_dest}, 16'd4);
        checkOutput("mulfData", bus.retire_data, 16'h8000);
        checkOutput("heldAddIn1", bus.alu_in1, 16'h0008);
        tick();
        checkOutput("heldAddRetire", {15'd0, bus.retire}, 16'd1);
        checkOutput("heldAddData", bus.retire_data, 16'h000D);
        tick();
        checkOutput("heldAddOnce", {15'd0, bus.retire}, 16'd0);
        checkReg("mulfR4", 6'd4, 16'h8000);

        // Illegal opcode: sticky flag, no writeback
        applyStimulus(1'b1, 16'hC041);
        tick();
        applyStimulus(1'b0, 16'd0);
        checkOutput("illegalSet", {15'd0, illegal}, 16'd1);
        tick();
        checkOutput("illegalNoRetire", {15'd0, bus.retire}, 16'd0);
        checkReg("illegalR1", 6'd1, 16'h000D);
        applyStimulus(1'b1, 16'h4000);
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        applyStimulus(1'b0, 16'd0);
        checkOutput("illegalSticky", {15'd0, illegal}, 16'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("illegalCleared", {15'd0, illegal}, 16'd0);

        // Reset during the second cycle of an addf aborts it
        dbgWrite(6'd1, 16'h0003);
        dbgWrite(6'd2, 16'h0005);
        applyStimulus(1'b1, 16'h2042);
        tick();
        applyStimulus(1'b0, 16'd0);
        tick();
        reset = 1'b1;
        tick();
        checkOutput("abortNoRetire", {15'd0, bus.retire}, 16'd0);
        reset = 1'b0;
        #1;
        checkOutput("abortReady", {15'd0, bus.ins_ready}, 16'd1);
        for (int r = 0; r < 64; r++) begin
            checkReg($sformatf("clearR%0d", r), 6'(r), 16'd0);
        end
        tick();
        checkOutput("abortStillNoRetire", {15'd0, bus.retire}, 16'd0);

        // Writeback beats a debug write to the same register
        dbgWrite(6'd6, 16'h1000);
        dbgWrite(6'd7, 16'h0234);
        applyStimulus(1'b1, 16'h0187);
        tick();
        applyStimulus(1'b0, 16'd0);
        dbgWe    = 1'b1;
        dbgAddr  = 6'd6;
        dbgWdata = 16'hBEEF;
        tick();
        dbgWe = 1'b0;
        checkOutput("collideData", bus.retire_data, 16'h1234);
        checkReg("collideR6", 6'd6, 16'h1234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Register-read / execute / writeback stage that feeds the combinational 16-bit ALU and consumes its result.
- Holds the 64 x 16-bit register file.
- Accepts one instruction word per cycle over a valid/ready handshake. Decodes Opcode[15:12], Dest[11:6] and Src[5:0], then drives op/in1/in2 to the external ALU and writes the ALU result back to Dest.
- Float ops (invf, addf, mulf) occupy the execute register for FP_LAT cycles; integer ops take 1 cycle.

Parameters:
FP_LAT, 2, cycles a float op (opcodes 1,2,3) holds the execute stage; legal 1..15
NREGS, 64, register file depth (fixed by the 6-bit Dest/Src fields)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
ins_valid  in  1  instruction word present
ins_ready  out  1  stage can accept an instruction this cycle
ins  in  16  instruction word {Opcode, Dest, Src}
alu_op  out  5  to ALU: {1'b0, ex_opcode}
alu_in1  out  16  to ALU: first operand
alu_in2  out  16  to ALU: second operand
alu_result  in  16  from ALU, combinational on alu_op/in1/in2
retire  out  1  one-cycle pulse: writeback occurred this edge
retire_dest  out  6  register written
retire_data  out  16  value written
illegal  out  1  sticky: an opcode 12..15 was accepted
dbg_we  in  1  debug register write
dbg_addr  in  6  debug read/write address
dbg_wdata  in  16  debug write data
dbg_rdata  out  16  combinational read of rf[dbg_addr]; no bypass

Behaviour:
- Reset (synchronous, active-high, clk edge with reset=1):
  - All 64 registers clear to 0.
  - ex_valid=0, counter=0, retire=0, retire_dest=0, retire_data=0, illegal=0.
  - alu_op/alu_in1/alu_in2 are registered and clear to 0.
  - Reset aborts any in-flight op with no writeback.
  - ins_ready=0 while reset is high.
- Accept: an instruction is accepted when ins_valid && ins_ready at a rising edge. On that edge the EX registers load ex_opcode, ex_dest, alu_in1, alu_in2, ex_valid=1 and counter=0.
- Operand selection:
  - Binary ops (add, addf, mulf, and, or, xor): in1=R[Dest], in2=R[Src].
  - Unary ops (invf, any, dup, shr, f2i, i2f): in1=in2=R[Src].
- Bypass: when a writeback of address A occurs on the same edge as an accept reading A, the operand takes alu_result (the value being written), not the stale rf value. This gives back-to-back dependent instructions with zero stalls.
- Execute / writeback:
  - Integer op: writeback on the first edge after accept.
  - Float op: counter increments each cycle; writeback on the edge where counter==FP_LAT-1, i.e. FP_LAT cycles after accept.
  - Writeback does: R[ex_dest] <= alu_result, retire=1 for one cycle with retire_dest/retire_data, ex_valid cleared unless a new instruction is accepted on the same edge.
- Ready: ins_ready = !reset && !(ex_valid && ex_is_float && counter != FP_LAT-1). With FP_LAT=1 it is always 1 outside reset.
- Illegal opcodes 12..15:
  - Accepted normally, no writeback, retire stays 0.
  - illegal sets and stays set until reset; the slot is consumed for 1 cycle.
- Debug write: R[dbg_addr] <= dbg_wdata on the edge. If writeback targets the same address on the same edge, writeback wins. Debug writes do not bypass into operand reads.
- Writeback to any register, including R0, is permitted; there is no hardwired zero.
- ins is ignored when ins_valid=0 or ins_ready=0. ins_valid held high while ready=0 must not be lost or duplicated.

Test Plan:
1. Reset, then dbg write R1=0x0003 and R2=0x0005. Accept add $1,$2 (0x0042) → next edge retire=1, dest=1, data=0x0008; dbg_rdata@1=0x0008.
2. Back-to-back: add $1,$2 then xor $3,$1 (0x40C1) with R3=0x00FF → xor sees in2=0x0008 via bypass; R3=0x00F7; no ready drop.
3. FP_LAT=2: R4=0x3F80 (1.0), R5=0x4000 (2.0). Accept mulf $4,$5, then hold the next instruction valid → ins_ready low for 1 cycle; retire 2 edges after accept with data equal to the ALU output; the following instruction is accepted exactly once.
4. Accept opcode 0xC (ins=0xC041) → illegal=1, no retire, R1 unchanged; illegal stays 1 across 10 further instructions; a reset clears it.
5. Assert reset during the second cycle of an addf → no retire ever for that op; all registers read 0; ins_ready=1 the cycle after reset deasserts.
6. dbg_we to R6 on the same edge as writeback to R6 with data 0x1234 → R6=0x1234 (writeback wins).
